// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory fetch controller: bridges the core's level fetch request
// to a request/grant + rvalid memory port, with window checks and a timeout.
module imem_fetch_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          MEM_AW    = 16,
  parameter int          TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       rom_addr,
  input  logic              rom_re,
  output logic [31:0]       rom_out,
  output logic              rom_oe,
  output logic              mem_req,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              err_oor,
  output logic              err_timeout,
  output logic [31:0]       fetch_count
);

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [63:0] WIN_WORDS = 64'd1 << MEM_AW;
  localparam logic [16:0] TMO_LIMIT = 17'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t              state, state_nxt;
  logic [31:0]         addr_q;
  logic [MEM_AW-1:0]   word_q;
  logic [15:0]         tmo_cnt;
  logic [31:0]         rel_addr;
  logic                in_range;
  logic                match;
  logic                tmo_hit;

  // Offset is taken modulo 2^32, so addresses below BASE_ADDR wrap high and fail.
  assign rel_addr = rom_addr - BASE_ADDR;
  assign in_range = (rom_addr[1:0] == 2'b00) && (({32'd0, rel_addr} >> 2) < WIN_WORDS);
  assign match    = rom_re && (rom_addr == addr_q);
  assign tmo_hit  = (({1'b0, tmo_cnt} + 17'd1) == TMO_LIMIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (rom_re) state_nxt = in_range ? REQ : RESP;
      REQ:  if (mem_gnt) state_nxt = WAIT;
      WAIT: begin
        if (mem_rvalid)   state_nxt = match ? RESP : IDLE;
        else if (tmo_hit) state_nxt = IDLE;
      end
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_req  = (state == REQ);
    rom_oe   = (state == RESP);
    mem_addr = (state == REQ) ? word_q : '0;
  end

  // Fetch address is only meaningful once latched in IDLE, so it needs no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && rom_re && in_range) begin
      addr_q <= rom_addr;
      word_q <= rel_addr[MEM_AW+1:2];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_out     <= '0;
      err_oor     <= 1'b0;
      err_timeout <= 1'b0;
      fetch_count <= '0;
      tmo_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rom_re && !in_range) begin
            rom_out <= NOP;
            err_oor <= 1'b1;
          end
        end
        REQ: begin
          if (mem_gnt) tmo_cnt <= '0;
        end
        WAIT: begin
          if (mem_rvalid) begin
            if (match) rom_out <= mem_rdata;
          end else if (tmo_hit) begin
            err_timeout <= 1'b1;
            tmo_cnt     <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        RESP: fetch_count <= fetch_count + 32'd1;
        default: ;
      endcase
    end
  end

endmodule
